// File: rtl/scmp_microcode_pak.sv
// ---------------------------------------------------------------------------
// scmp_microcode_pak
// Shared types and constants for the SC/MP microcoded core.
//   ALU_OP_t      - operation select for the shared 8-bit ALU
//   EA_MODE_t     - effective-address addressing modes
//   EA_DISP_USE_E - displacement value that selects the E register instead
//   ea_eff_disp() - resolves the displacement actually used for an EA
// ---------------------------------------------------------------------------
package scmp_microcode_pak;

    typedef enum logic [2:0] {
        ALU_OP_OR  = 3'd0,
        ALU_OP_AND = 3'd1,
        ALU_OP_XOR = 3'd2,
        ALU_OP_ADD = 3'd3,
        ALU_OP_DAD = 3'd4
    } ALU_OP_t;

    typedef enum logic [1:0] {
        EA_PCREL   = 2'd0,
        EA_INDEXED = 2'd1,
        EA_AUTO    = 2'd2
    } EA_MODE_t;

    // A displacement of -128 is never used literally; it means "use E".
    localparam logic [7:0] EA_DISP_USE_E = 8'h80;

    function automatic logic [7:0] ea_eff_disp(input logic [7:0] disp,
                                               input logic [7:0] e_reg);
        logic [7:0] d;
        if (disp == EA_DISP_USE_E) begin
            d = e_reg;
        end else begin
            d = disp;
        end
        return d;
    endfunction

endpackage

// File: rtl/scmp_ea_seq_if.sv
// ---------------------------------------------------------------------------
// scmp_ea_seq_if
// Request/response bundle between the instruction decoder and the
// effective-address sequencer.
//   master (decoder)  : drives req_i, mode_i, ptr_i, disp_i, e_i
//                       observes ready_o, done_o, ea_o, ptr_wb_o, ptr_we_o
//   slave  (sequencer): the mirror image
// ---------------------------------------------------------------------------
interface scmp_ea_seq_if
    import scmp_microcode_pak::*;
;
    logic        req_i;
    EA_MODE_t    mode_i;
    logic [15:0] ptr_i;
    logic [7:0]  disp_i;
    logic [7:0]  e_i;
    logic        ready_o;
    logic        done_o;
    logic [15:0] ea_o;
    logic [15:0] ptr_wb_o;
    logic        ptr_we_o;

    modport master (
        output req_i, mode_i, ptr_i, disp_i, e_i,
        input  ready_o, done_o, ea_o, ptr_wb_o, ptr_we_o
    );

    modport slave (
        input  req_i, mode_i, ptr_i, disp_i, e_i,
        output ready_o, done_o, ea_o, ptr_wb_o, ptr_we_o
    );

endinterface

// File: rtl/scmp_ea_seq.sv
// ---------------------------------------------------------------------------
// scmp_ea_seq
// Effective-address sequencer. Forms a 16-bit operand address by running two
// ADD passes through the external shared ALU (low byte, then high byte with a
// sign-extension byte), keeps the 4-bit page fixed, and produces the pointer
// write-back value for auto-indexed addressing.
// Ports:
//   clk, rst_n     - core clock, asynchronous active-low reset
//   ea_bus         - decoder request/response bundle (slave side)
//   alu_op_o       - ALU operation (ADD during LO/HI, OR pass-through else)
//   alu_a_o/b_o    - ALU operands
//   alu_cy_o       - ALU carry-in
//   alu_res_i      - ALU result
//   alu_cy_i       - ALU carry-out
//   alu_cysgn_i    - ALU sign-of-B flag
// ---------------------------------------------------------------------------
module scmp_ea_seq
    import scmp_microcode_pak::*;
(
    input  logic                clk,
    input  logic                rst_n,
    scmp_ea_seq_if.slave        ea_bus,
    output ALU_OP_t             alu_op_o,
    output logic [7:0]          alu_a_o,
    output logic [7:0]          alu_b_o,
    output logic                alu_cy_o,
    input  logic [7:0]          alu_res_i,
    input  logic                alu_cy_i,
    input  logic                alu_cysgn_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;

    EA_MODE_t    mode_r;
    logic [15:0] ptr_r;
    logic [7:0]  d_r;
    logic [7:0]  sum_lo_r;
    logic        c_r;
    logic        s_r;

    logic [15:0] sum_s;
    logic [15:0] ea_sel_s;

    logic        ready_r;
    logic        done_r;
    logic        ptr_we_r;
    logic [15:0] ea_r;
    logic [15:0] ptr_wb_r;

    // Next-state decode; a request is only taken in the two ready states.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (ea_bus.req_i) begin
                    state_next_s = S_LO;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LO: begin
                state_next_s = S_HI;
            end
            S_HI: begin
                state_next_s = S_DONE;
            end
            S_DONE: begin
                if (ea_bus.req_i) begin
                    state_next_s = S_LO;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // ALU drive: ADD passes in LO/HI, otherwise a flag-neutral OR of zeros.
    always_comb begin
        alu_op_o = ALU_OP_OR;
        alu_a_o  = 8'h00;
        alu_b_o  = 8'h00;
        alu_cy_o = 1'b0;
        case (state_r)
            S_LO: begin
                alu_op_o = ALU_OP_ADD;
                alu_a_o  = ptr_r[7:0];
                alu_b_o  = d_r;
                alu_cy_o = 1'b0;
            end
            S_HI: begin
                alu_op_o = ALU_OP_ADD;
                alu_a_o  = ptr_r[15:8];
                // Sign-extension byte of the displacement, as flagged by the ALU.
                if (s_r) begin
                    alu_b_o = 8'hFF;
                end else begin
                    alu_b_o = 8'h00;
                end
                alu_cy_o = c_r;
            end
            default: begin
                alu_op_o = ALU_OP_OR;
                alu_a_o  = 8'h00;
                alu_b_o  = 8'h00;
                alu_cy_o = 1'b0;
            end
        endcase
    end

    // Full sum during HI; the page nibble never changes, so any carry or
    // borrow out of bit 11 is simply dropped.
    assign sum_s = {ptr_r[15:12], alu_res_i[3:0], sum_lo_r};

    // Operand address selection; post-increment auto mode uses the old pointer.
    always_comb begin
        ea_sel_s = sum_s;
        if ((mode_r == EA_AUTO) && !d_r[7]) begin
            ea_sel_s = ptr_r;
        end else begin
            ea_sel_s = sum_s;
        end
    end

    // Request capture and low-pass intermediate results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= EA_PCREL;
            ptr_r    <= 16'h0000;
            d_r      <= 8'h00;
            sum_lo_r <= 8'h00;
            c_r      <= 1'b0;
            s_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                mode_r <= ea_bus.mode_i;
                ptr_r  <= ea_bus.ptr_i;
                d_r    <= ea_eff_disp(ea_bus.disp_i, ea_bus.e_i);
            end
            if (state_r == S_LO) begin
                sum_lo_r <= alu_res_i;
                c_r      <= alu_cy_i;
                s_r      <= alu_cysgn_i;
            end
        end
    end

    // Registered results; ea/ptr_wb hold from one completion to the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea_r     <= 16'h0000;
            ptr_wb_r <= 16'h0000;
        end else if (state_r == S_HI) begin
            ea_r     <= ea_sel_s;
            ptr_wb_r <= sum_s;
        end
    end

    // Registered handshake flags, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            ptr_we_r <= 1'b0;
        end else begin
            ready_r  <= (state_next_s == S_IDLE) || (state_next_s == S_DONE);
            done_r   <= (state_next_s == S_DONE);
            ptr_we_r <= (state_next_s == S_DONE) && (mode_r == EA_AUTO);
        end
    end

    assign ea_bus.ready_o  = ready_r;
    assign ea_bus.done_o   = done_r;
    assign ea_bus.ptr_we_o = ptr_we_r;
    assign ea_bus.ea_o     = ea_r;
    assign ea_bus.ptr_wb_o = ptr_wb_r;

endmodule

// File: tb/tb_scmp_ea_seq.sv
// ---------------------------------------------------------------------------
// tb_scmp_ea_seq
// Self-checking bench for scmp_ea_seq with an external behavioural ALU and a
// reference address model computed with plain 16-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_scmp_ea_seq;
    import scmp_microcode_pak::*;

    logic        clk;
    logic        rst_n;
    ALU_OP_t     alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cy;
    logic [7:0]  alu_res;
    logic        alu_cy_ret;
    logic        alu_cysgn;

    int n_cmp;
    int n_err;

    scmp_ea_seq_if eif();

    scmp_ea_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ea_bus     (eif),
        .alu_op_o   (alu_op),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_cy_o   (alu_cy),
        .alu_res_i  (alu_res),
        .alu_cy_i   (alu_cy_ret),
        .alu_cysgn_i(alu_cysgn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU (only the ops this block uses matter).
    always_comb begin
        alu_res    = 8'h00;
        alu_cy_ret = 1'b0;
        alu_cysgn  = 1'b0;
        case (alu_op)
            ALU_OP_ADD: begin
                {alu_cy_ret, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cy};
                alu_cysgn = alu_b[7];
            end
            ALU_OP_OR: begin
                alu_res = alu_a | alu_b;
            end
            default: begin
                alu_res = 8'h00;
            end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: displacement sign-extended, added, page nibble restored.
    function automatic logic [15:0] ref_sum(input logic [15:0] p, input logic [7:0] dsp,
                                            input logic [7:0] ev);
        logic [7:0]  d;
        logic [15:0] full;
        d    = (dsp == 8'h80) ? ev : dsp;
        full = p + {{8{d[7]}}, d};
        return {p[15:12], full[11:0]};
    endfunction

    function automatic logic [15:0] ref_ea(input EA_MODE_t m, input logic [15:0] p,
                                           input logic [7:0] dsp, input logic [7:0] ev);
        logic [7:0] d;
        d = (dsp == 8'h80) ? ev : dsp;
        if (m == EA_AUTO && d[7] == 1'b0) return p;
        return ref_sum(p, dsp, ev);
    endfunction

    task automatic scramble();
        eif.mode_i = EA_MODE_t'(2'($urandom_range(2)));
        eif.ptr_i  = 16'($urandom);
        eif.disp_i = 8'($urandom);
        eif.e_i    = 8'($urandom);
    endtask

    // One full calculation; starts in a ready state, returns in the DONE cycle.
    task automatic run_ea(input EA_MODE_t m, input logic [15:0] p, input logic [7:0] dsp,
                          input logic [7:0] ev, input logic noisy);
        logic [7:0] d;
        logic [8:0] lo;
        d  = (dsp == 8'h80) ? ev : dsp;
        lo = {1'b0, p[7:0]} + {1'b0, d};
        check_val("ready_at_req", 32'(eif.ready_o), 32'd1);
        eif.req_i  = 1'b1;
        eif.mode_i = m;
        eif.ptr_i  = p;
        eif.disp_i = dsp;
        eif.e_i    = ev;
        tick();
        eif.req_i = noisy ? 1'($urandom_range(1)) : 1'b0;
        if (noisy) scramble();
        check_val("lo_op", 32'(alu_op), 32'(ALU_OP_ADD));
        check_val("lo_a", 32'(alu_a), 32'(p[7:0]));
        check_val("lo_b", 32'(alu_b), 32'(d));
        check_val("lo_cy", 32'(alu_cy), 32'd0);
        check_val("lo_ready", 32'(eif.ready_o), 32'd0);
        check_val("lo_done", 32'(eif.done_o), 32'd0);
        tick();
        eif.req_i = noisy ? 1'($urandom_range(1)) : 1'b0;
        if (noisy) scramble();
        check_val("hi_op", 32'(alu_op), 32'(ALU_OP_ADD));
        check_val("hi_a", 32'(alu_a), 32'(p[15:8]));
        check_val("hi_b", 32'(alu_b), d[7] ? 32'hFF : 32'h00);
        check_val("hi_cy", 32'(alu_cy), 32'(lo[8]));
        check_val("hi_done", 32'(eif.done_o), 32'd0);
        tick();
        eif.req_i = 1'b0;
        check_val("done", 32'(eif.done_o), 32'd1);
        check_val("done_ready", 32'(eif.ready_o), 32'd1);
        check_val("ea", 32'(eif.ea_o), 32'(ref_ea(m, p, dsp, ev)));
        check_val("ptr_wb", 32'(eif.ptr_wb_o), 32'(ref_sum(p, dsp, ev)));
        check_val("ptr_we", 32'(eif.ptr_we_o), (m == EA_AUTO) ? 32'd1 : 32'd0);
        check_val("done_alu_op", 32'(alu_op), 32'(ALU_OP_OR));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(eif.ready_o), 32'd1);
        check_val({tag, "_done"}, 32'(eif.done_o), 32'd0);
        check_val({tag, "_we"}, 32'(eif.ptr_we_o), 32'd0);
        check_val({tag, "_ea"}, 32'(eif.ea_o), 32'd0);
        check_val({tag, "_wb"}, 32'(eif.ptr_wb_o), 32'd0);
        check_val({tag, "_op"}, 32'(alu_op), 32'(ALU_OP_OR));
        check_val({tag, "_alu"}, {15'd0, alu_cy, alu_a, alu_b}, 32'd0);
    endtask

    initial begin
        EA_MODE_t m;
        logic [15:0] p;
        logic [7:0]  dsp;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        eif.req_i  = 1'b0;
        eif.mode_i = EA_PCREL;
        eif.ptr_i  = 16'h0000;
        eif.disp_i = 8'h00;
        eif.e_i    = 8'h00;
        tick();
        tick();
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Directed cases.
        run_ea(EA_INDEXED, 16'h1234, 8'h10, 8'h00, 1'b0);
        tick();
        run_ea(EA_INDEXED, 16'h2005, 8'hF0, 8'h00, 1'b0);
        run_ea(EA_INDEXED, 16'h3FFF, 8'h01, 8'h00, 1'b0);
        run_ea(EA_INDEXED, 16'h30FF, 8'h01, 8'h00, 1'b0);
        run_ea(EA_PCREL,   16'h1000, 8'h80, 8'h05, 1'b0);
        run_ea(EA_PCREL,   16'h1000, 8'h80, 8'hFE, 1'b0);
        run_ea(EA_AUTO,    16'h1010, 8'hFF, 8'h00, 1'b0);
        run_ea(EA_AUTO,    16'h1010, 8'h02, 8'h00, 1'b1);
        tick();
        check_val("idle_after_done", 32'(eif.done_o), 32'd0);
        check_val("hold_ea", 32'(eif.ea_o), 32'h1010);
        check_val("hold_wb", 32'(eif.ptr_wb_o), 32'h1012);

        // req held high: done on every third cycle.
        eif.req_i  = 1'b1;
        eif.mode_i = EA_INDEXED;
        eif.ptr_i  = 16'h4567;
        eif.disp_i = 8'h22;
        eif.e_i    = 8'h00;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_val($sformatf("stream_done_%0d", k), 32'(eif.done_o),
                      (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k % 3 == 0) check_val("stream_ea", 32'(eif.ea_o), 32'h4589);
        end
        eif.req_i = 1'b0;
        tick();

        // Reset during HI aborts the calculation.
        eif.req_i  = 1'b1;
        eif.mode_i = EA_AUTO;
        eif.ptr_i  = 16'h5555;
        eif.disp_i = 8'h81;
        tick();
        eif.req_i = 1'b0;
        tick();
        check_val("abort_in_hi", 32'(alu_op), 32'(ALU_OP_ADD));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("no_done_after_rst", {30'd0, eif.done_o, eif.ptr_we_o}, 32'd0);
        end
        run_ea(EA_AUTO, 16'h5555, 8'h81, 8'h00, 1'b0);

        // Randomized transactions, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            m   = EA_MODE_t'(2'($urandom_range(2)));
            p   = 16'($urandom);
            dsp = ($urandom_range(7) == 0) ? 8'h80 : 8'($urandom);
            run_ea(m, p, dsp, 8'($urandom), 1'($urandom_range(1)));
            if ($urandom_range(1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scmp_ea_seq.md
# scmp_ea_seq

Effective-address sequencer for the SC/MP core. It forms the 16-bit memory-reference address by driving the shared 8-bit ALU for two ADD passes (low byte, then high byte). It applies SC/MP page-wrap and E-register displacement rules, and produces pointer write-back for auto-indexed mode. It sits between the instruction decoder and the ALU; the ALU is instantiated outside so the core datapath can share it when this block is idle.

## Interface

- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  start EA calculation; sampled only when ready_o=1
- mode_i  in  EA_MODE_t  EA_PCREL, EA_INDEXED, EA_AUTO
- ptr_i  in  16  base pointer (PC or P1–P3), captured on accept
- disp_i  in  8  signed displacement, captured on accept
- e_i  in  8  E register, captured on accept
- ready_o  out  1  block can accept req_i this cycle
- done_o  out  1  one-cycle pulse; ea_o/ptr_wb_o valid
- ea_o  out  16  operand address
- ptr_wb_o  out  16  new pointer value (auto mode)
- ptr_we_o  out  1  one-cycle pulse with done_o, EA_AUTO only
- alu_op_o  out  ALU_OP_t  ALU operation
- alu_a_o, alu_b_o  out  8  ALU operands
- alu_cy_o  out  1  ALU carry-in
- alu_res_i  in  8  ALU result
- alu_cy_i  in  1  ALU carry-out
- alu_cysgn_i  in  1  ALU sign-of-B flag (high for negative B on ADD)

## Operation

- Effective displacement d = (disp_i==EA_DISP_USE_E) ? e_i : disp_i, in all modes; latched on accept.
- States: IDLE, LO, HI, DONE.
  - IDLE: ready_o=1; on req_i go to LO.
  - LO: alu_op_o=ALU_OP_ADD, A=ptr[7:0], B=d, Cy=0. Latch sum_lo=alu_res_i, c=alu_cy_i, s=alu_cysgn_i. Go to HI.
  - HI: alu_op_o=ALU_OP_ADD, A=ptr[15:8], B=s?8'hFF:8'h00, Cy=c. Latch sum_hi=alu_res_i. Go to DONE.
  - DONE: ready_o=1, done_o=1. On req_i go to LO (back-to-back); otherwise go to IDLE.
- Page wrap: sum[15:12] = ptr[15:12]; only sum[11:0] takes the ALU result. Carry/borrow out of bit 11 is discarded.
- ea_o: PCREL/INDEXED use sum. AUTO with d[7]=1 (pre-decrement) uses sum. AUTO with d[7]=0 (post-increment) uses ptr.
- ptr_wb_o = sum in all modes. ptr_we_o pulses only for AUTO.
- Outside LO/HI: alu_op_o=ALU_OP_OR, alu_b_o=0, alu_cy_o=0, alu_a_o=0 (pass-through, no flag effect).
- req_i while ready_o=0 is ignored, not queued. Inputs are not re-sampled after accept.
- ALU Ov output is unused. Carry is never reported upstream.

## Timing

- Reset (async assert, sync-safe release): state=IDLE, ready_o=1, done_o=0, ptr_we_o=0, ea_o=0, ptr_wb_o=0, alu_* outputs=0 with alu_op_o=ALU_OP_OR. All latched operands are 0.
- Latency: req_i accepted at edge N; LO runs in cycle N+1, HI in N+2, done_o is high in N+3.
- Throughput: one EA per 3 cycles with back-to-back req in DONE.
- ea_o/ptr_wb_o hold their value from done until the next done.
- Reset during LO/HI aborts the calculation; no done_o or ptr_we_o follows.
- ALU is combinational: results are sampled at the end of the same cycle the operands are driven.

## Structure

- Add to scmp_microcode_pak: typedef enum EA_MODE_t {EA_PCREL, EA_INDEXED, EA_AUTO}, and localparam EA_DISP_USE_E = 8'h80.
- State enum is local to the module.
- Single module, no sub-module. The ALU stays external, shared with the core datapath.

## Test plan

- INDEXED, ptr 0x1234, disp 0x10 -> done_o at cycle 3 after accept, ea_o=0x1244, ptr_we_o=0. Check the two ALU ADD cycles with B=0x10 then 0x00.
- INDEXED, ptr 0x2005, disp 0xF0 -> HI cycle drives B=0xFF; ea_o=0x2FF5 (page wrap). Separately, ptr 0x3FFF, disp 0x01 -> 0x3000; ptr 0x30FF, disp 0x01 -> 0x3100.
- PCREL, ptr 0x1000, disp 0x80, e_i 0x05 -> ea_o=0x1005. Then e_i 0xFE -> ea_o=0x1FFE.
- AUTO, ptr 0x1010, disp 0xFF -> ea_o=0x100F, ptr_wb_o=0x100F, ptr_we_o=1. AUTO with disp 0x02 -> ea_o=0x1010, ptr_wb_o=0x1012.
- req_i held high continuously -> done_o every 3rd cycle. A second req asserted during LO/HI is ignored. Inputs changed after accept do not alter ea_o.
- rst_n asserted during HI -> all outputs 0, ready_o=1 immediately; no done_o after release. A new req then completes normally.
